// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store initiator: access sizes,
// controller states and byte-lane geometry of the big-endian memory word.
package mips_mem_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;
  localparam int LANES  = WORD_W / BYTE_W;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_t;

  // Reserved size and naturally misaligned halfwords/words are refused.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: access_fault = 1'b0;
      SIZE_HALF: access_fault = offset[0];
      SIZE_WORD: access_fault = |offset;
      default:   access_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Big-endian lane logic: extracts/extends load data from a memory word and
// merges sub-word store data into the old word for read-modify-write.
module mem_lane_merge
  import mips_mem_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] store_o
);

  logic [BYTE_W-1:0] lane [LANES];
  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  // Lane 0 is the most significant byte.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int         HI  = WORD_W - 1 - gi * BYTE_W;
    localparam logic [1:0] IDX = 2'(gi);
    logic              hit;
    logic [BYTE_W-1:0] new_byte;

    assign lane[gi] = word_i[HI -: BYTE_W];
    assign hit = (size_i == SIZE_WORD)
              || (size_i == SIZE_BYTE && offset_i == IDX)
              || (size_i == SIZE_HALF && offset_i[1] == IDX[1]);
    assign new_byte = (size_i == SIZE_WORD)                ? data_i[HI -: BYTE_W] :
                      (size_i == SIZE_HALF && !IDX[0])     ? data_i[HALF_W-1:BYTE_W] :
                                                             data_i[BYTE_W-1:0];
    assign store_o[HI -: BYTE_W] = hit ? new_byte : lane[gi];
  end

  always_comb begin
    byte_sel = lane[offset_i];
    half_sel = offset_i[1] ? {lane[2], lane[3]} : {lane[0], lane[1]};
    case (size_i)
      SIZE_BYTE: load_o = {{(WORD_W-BYTE_W){signed_i & byte_sel[BYTE_W-1]}}, byte_sel};
      SIZE_HALF: load_o = {{(WORD_W-HALF_W){signed_i & half_sel[HALF_W-1]}}, half_sel};
      default:   load_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-wide memory; sub-word
// stores are done as read-modify-write, misaligned requests never touch memory.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] Address,
  output logic [31:0] writeData,
  output logic        writeEnable,
  input  logic [31:0] MemData
);

  localparam int              CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              signed_q, signed_d;
  logic              err_q, err_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wr_word_q, wr_word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       load_word;
  logic [31:0]       store_word;

  mem_lane_merge u_merge (
    .word_i   (MemData),
    .data_i   (wdata_q),
    .offset_i (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .load_o   (load_word),
    .store_o  (store_word)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= SIZE_BYTE;
      off_q     <= 2'b00;
      wdata_q   <= '0;
      addr_q    <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      signed_q  <= signed_d;
      err_q     <= err_d;
      size_q    <= size_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      wr_word_q <= wr_word_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    signed_d  = signed_q;
    err_d     = err_q;
    size_d    = size_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    wr_word_d = wr_word_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          signed_d = req_signed;
          size_d   = req_size;
          off_d    = req_addr[1:0];
          wdata_d  = req_wdata;
          cnt_d    = '0;
          rdata_d  = '0;
          err_d    = 1'b0;
          // Faulting requests leave the memory-side registers untouched.
          if (access_fault(req_size, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            addr_d = {req_addr[31:2], 2'b00};
            if (req_write && req_size == SIZE_WORD) begin
              wr_word_d = req_wdata;
              state_d   = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (cnt_q == CNT_LAST) begin
          if (write_q) begin
            wr_word_d = store_word;
            state_d   = ST_WRITE;
          end else begin
            rdata_d = load_word;
            state_d = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign writeEnable = (state_q == ST_WRITE);
  assign resp_rdata  = (state_q == ST_RESP) ? rdata_q : '0;
  assign resp_err    = (state_q == ST_RESP) & err_q;
  assign Address     = addr_q;
  assign writeData   = wr_word_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (latency 1 and 3) share one word
// memory; table vectors, random vectors from a byte-level model, and corner sequences.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_word;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  int          sel = 0;

  logic        v1, rdy1, rv1, re1, we1;
  logic [31:0] rd1, a1, wd1, md1;
  logic        v3, rdy3, rv3, re3, we3;
  logic [31:0] rd3, a3, wd3, md3;

  logic [31:0] mem [64];
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0, ld_data = '0;

  int total = 0;
  int bad = 0;

  assign v1  = req_valid && (sel == 0);
  assign v3  = req_valid && (sel == 1);
  assign md1 = mem[a1[7:2]];
  assign md3 = mem[a3[7:2]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr[7:2]] <= ld_data;
    if (we1)   mem[a1[7:2]] <= wd1;
    if (we3)   mem[a3[7:2]] <= wd3;
  end

  logic        cur_ready, cur_resp, cur_err, cur_we;
  logic [31:0] cur_rdata, cur_addr, cur_wd;
  assign cur_ready = (sel == 1) ? rdy3 : rdy1;
  assign cur_resp  = (sel == 1) ? rv3  : rv1;
  assign cur_err   = (sel == 1) ? re3  : re1;
  assign cur_we    = (sel == 1) ? we3  : we1;
  assign cur_rdata = (sel == 1) ? rd3  : rd1;
  assign cur_addr  = (sel == 1) ? a3   : a1;
  assign cur_wd    = (sel == 1) ? wd3  : wd1;

  mem_access_unit #(.READ_LATENCY(1)) dut1 (
    .Clk(clk), .Reset(rst), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1), .Address(a1), .writeData(wd1),
    .writeEnable(we1), .MemData(md1)
  );

  mem_access_unit #(.READ_LATENCY(3)) dut3 (
    .Clk(clk), .Reset(rst), .req_valid(v3), .req_ready(rdy3), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(re3), .Address(a3), .writeData(wd3),
    .writeEnable(we3), .MemData(md3)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // Reference: treat the word as four big-endian bytes and operate on them directly.
  task automatic model(input logic w, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] word,
                       output logic [31:0] rdata, output logic err, output logic [31:0] nword);
    logic [7:0] b [4];
    int off, v;
    for (int i = 0; i < 4; i++) b[i] = word[31-8*i -: 8];
    off   = int'(addr[1:0]);
    err   = (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0);
    rdata = 0;
    nword = word;
    if (!err && !w) begin
      if (sz == 2'd0) begin
        v = int'(b[off]);
        if (sgn && v >= 128) v = v - 256;
        rdata = 32'(v);
      end else if (sz == 2'd1) begin
        v = int'(b[off]) * 256 + int'(b[off+1]);
        if (sgn && v >= 32768) v = v - 65536;
        rdata = 32'(v);
      end else begin
        rdata = word;
      end
    end else if (!err) begin
      if (sz == 2'd0) b[off] = wdata[7:0];
      else if (sz == 2'd1) begin
        b[off] = wdata[15:8];
        b[off+1] = wdata[7:0];
      end else for (int i = 0; i < 4; i++) b[i] = wdata[31-8*i -: 8];
      nword = {b[0], b[1], b[2], b[3]};
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int L, exp_lat, exp_wek, lat, we_n, we_k;
    logic [31:0] exp_addr, wd_at, rd;
    logic er, addr_ok;
    L = (sel == 1) ? 3 : 1;
    lat = 0; we_n = 0; we_k = 0; wd_at = '0; rd = '0; er = 1'b0; addr_ok = 1'b1;
    preload(v.addr, v.init);
    exp_addr = v.exp_err ? cur_addr : {v.addr[31:2], 2'b00};
    exp_lat  = v.exp_err ? 1 : (v.w && v.sz == 2'd2) ? 2 : v.w ? L + 2 : L + 1;
    exp_wek  = (v.sz == 2'd2) ? 1 : L + 1;
    chk({tag, "_ready"}, 32'(cur_ready), 32'd1);
    req_write = v.w; req_size = v.sz; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (cur_we) begin we_n++; we_k = k; wd_at = cur_wd; end
      if (cur_addr !== exp_addr) addr_ok = 1'b0;
      if (cur_resp) begin lat = k; rd = cur_rdata; er = cur_err; break; end
    end
    $display("txn L=%0d %s w=%0d sz=%0d sgn=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             L, tag, v.w, v.sz, v.sgn, v.addr, v.wdata, rd, er, lat);
    chk({tag, "_resp_cycle"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(er), 32'(v.exp_err));
    chk({tag, "_rdata"}, rd, v.exp_rdata);
    chk({tag, "_we_count"}, 32'(we_n), (v.w && !v.exp_err) ? 32'd1 : 32'd0);
    chk({tag, "_addr_stable"}, 32'(addr_ok), 32'd1);
    chk({tag, "_mem_word"}, mem[v.addr[7:2]], v.exp_word);
    if (we_n > 0) begin
      chk({tag, "_we_cycle"}, 32'(we_k), 32'(exp_wek));
      chk({tag, "_wdata"}, wd_at, v.exp_word);
    end
  endtask

  task automatic reset_mid(input int s, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] init, input int rst_cyc,
                           input int exp_we, input logic [31:0] exp_word, input string tag);
    int we_n, rv_n;
    we_n = 0; rv_n = 0;
    sel = s;
    preload(addr, init);
    req_write = 1'b1; req_size = sz; req_signed = 1'b0;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= rst_cyc; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      we_n += int'(cur_we); rv_n += int'(cur_resp);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, "_ready_after"}, 32'(cur_ready), 32'd1);
      we_n += int'(cur_we); rv_n += int'(cur_resp);
    end
    $display("txn L=%0d %s reset in cycle %0d we=%0d resp=%0d mem=%h",
             (s == 1) ? 3 : 1, tag, rst_cyc, we_n, rv_n, mem[addr[7:2]]);
    chk({tag, "_we_count"}, 32'(we_n), 32'(exp_we));
    chk({tag, "_resp_count"}, 32'(rv_n), 32'd0);
    chk({tag, "_mem_word"}, mem[addr[7:2]], exp_word);
  endtask

  task automatic back_to_back();
    int acc [2];
    int rsp [2];
    logic [31:0] rdt [2];
    int na, nr;
    na = 0; nr = 0;
    sel = 1;
    preload(32'h0C, 32'hA1B2C3D4);
    preload(32'hFC, 32'h55667788);
    req_write = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0;
    req_addr = 32'h0C; req_valid = 1'b1;
    for (int t = 0; t < 40 && nr < 2; t++) begin
      if (t > 0) @(negedge clk);
      if (na == 1) req_addr = 32'hFC;
      if (na == 2) req_valid = 1'b0;
      if (cur_resp && nr < 2) begin rsp[nr] = t; rdt[nr] = cur_rdata; nr++; end
      if (req_valid && cur_ready && na < 2) begin acc[na] = t; na++; end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(na), 32'd2);
    chk("b2b_resps", 32'(nr), 32'd2);
    if (na == 2 && nr == 2) begin
      $display("txn L=3 b2b acc=%0d,%0d resp=%0d,%0d rdata=%h,%h",
               acc[0], acc[1], rsp[0], rsp[1], rdt[0], rdt[1]);
      chk("b2b_lat1", 32'(rsp[0] - acc[0]), 32'd4);
      chk("b2b_lat2", 32'(rsp[1] - acc[1]), 32'd4);
      chk("b2b_gap", 32'(acc[1] - rsp[0]), 32'd1);
      chk("b2b_rdata1", rdt[0], 32'hA1B2C3D4);
      chk("b2b_rdata2", rdt[1], 32'h55667788);
    end
  endtask

  vec_t tbl [15];
  vec_t rv;

  initial begin
    //           w    sz    sgn   addr     wdata          init           exp_rdata      err   exp_word
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h0C, 32'hF0F0F0F0, 32'h00000000, 32'h00000000, 1'b0, 32'hF0F0F0F0};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h0D, 32'h0,        32'h11A23344, 32'hFFFFFFA2, 1'b0, 32'h11A23344};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h0D, 32'h0,        32'h11A23344, 32'h000000A2, 1'b0, 32'h11A23344};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h0E, 32'hFFFFFF55, 32'h11223344, 32'h00000000, 1'b0, 32'h11225544};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h0F, 32'h0,        32'h11223344, 32'h00000000, 1'b1, 32'h11223344};
    tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h0E, 32'h0,        32'h1122F344, 32'hFFFFF344, 1'b0, 32'h1122F344};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h0C, 32'h0000ABCD, 32'h11223344, 32'h00000000, 1'b0, 32'hABCD3344};
    tbl[7]  = '{1'b0, 2'd2, 1'b1, 32'h10, 32'h0,        32'h80000001, 32'h80000001, 1'b0, 32'h80000001};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'h12345678, 32'h00000000, 1'b1, 32'h12345678};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h12, 32'h01020304, 32'hCAFEBABE, 32'h00000000, 1'b1, 32'hCAFEBABE};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h11223384, 32'hFFFFFF84, 1'b0, 32'h11223384};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'hF1223344, 32'h000000F1, 1'b0, 32'hF1223344};
    tbl[12] = '{1'b1, 2'd0, 1'b0, 32'h0F, 32'h000000EE, 32'h11223344, 32'h00000000, 1'b0, 32'h112233EE};
    tbl[13] = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h12349876, 32'hAABBCCDD, 32'h00000000, 1'b0, 32'hAABB9876};
    tbl[14] = '{1'b0, 2'd1, 1'b0, 32'h20, 32'h0,        32'h8001FFFF, 32'h00008001, 1'b0, 32'h8001FFFF};

    // Requests presented during reset must be ignored.
    preload(32'h20, 32'h0);
    sel = 0;
    req_write = 1'b1; req_size = SIZE_WORD; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready1", 32'(rdy1), 32'd1);
    chk("rst_ready3", 32'(rdy3), 32'd1);
    chk("rst_addr", a1, 32'h0);
    chk("rst_wdata", wd1, 32'h0);
    chk("rst_we", 32'(we1), 32'd0);
    chk("rst_resp_valid", 32'(rv1), 32'd0);
    chk("rst_rdata", rd1, 32'h0);
    chk("rst_err", 32'(re1), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ignored_mem", mem[8], 32'h0);
    $display("txn reset phase checked");

    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    reset_mid(0, SIZE_BYTE, 32'h0E, 32'hFFFFFF55, 32'h11223344, 1, 0, 32'h11223344, "rst_read_L1");
    reset_mid(1, SIZE_BYTE, 32'h0E, 32'hFFFFFF55, 32'h11223344, 3, 0, 32'h11223344, "rst_read_L3");
    reset_mid(0, SIZE_WORD, 32'h14, 32'h12345678, 32'h0BADF00D, 1, 1, 32'h12345678, "rst_write_L1");

    back_to_back();

    for (int n = 0; n < 80; n++) begin
      sel = n % 2;
      rv.w     = 1'($urandom_range(0, 1));
      rv.sz    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rv.sgn   = 1'($urandom_range(0, 1));
      rv.addr  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (rv.sz == 2'd1) rv.addr[0] = 1'b0;
        if (rv.sz == 2'd2) rv.addr[1:0] = 2'b00;
      end
      rv.wdata = $urandom;
      rv.init  = $urandom;
      model(rv.w, rv.sz, rv.sgn, rv.addr, rv.wdata, rv.init, rv.exp_rdata, rv.exp_err, rv.exp_word);
      run_vec(rv, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the MIPS datapath's MEM stage and the word-wide `Memory` block, and drives that block's `Address`/`writeData`/`writeEnable` inputs while consuming `MemData`. It accepts one byte, halfword or word request at a time over a valid/ready handshake. Sub-word stores are done as read-modify-write, because `Memory` only writes full words. It returns sign- or zero-extended load data, and flags misaligned accesses without touching memory.

## Interface
- `READ_LATENCY`, default 1: cycles `Address` is held before `MemData` is sampled (≥1).
- `Clk`  in  1  single clock; `Memory` writes on posedge `Clk`.
- `Reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; request accepted on `req_valid & req_ready` at posedge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_signed`  in  1  sign-extend load result.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse; no back-pressure.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or reserved size; valid with `resp_valid`.
- `Address`  out  32  word-aligned address to `Memory` (bits 1:0 always 0).
- `writeData`  out  32  word to `Memory`.
- `writeEnable`  out  1  write strobe to `Memory`.
- `MemData`  in  32  read word from `Memory`.

## Operation
- Byte order is big-endian. Byte offset 0 is `[31:24]` and offset 3 is `[7:0]`. Halfword offset 0 is `[31:16]`.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On acceptance, latch the request and `Address <= {req_addr[31:2],2'b00}`.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) or size 11 → RESP with `resp_err`=1. `Address` and `writeData` are left unchanged.
  - Word store → WRITE with `writeData <= req_wdata`.
  - Any load or sub-word store → READ.
- READ: counter runs from 0 to READ_LATENCY-1. On the last count, `MemData` is captured.
  - For a load, extract the lane, extend per `req_signed`, then → RESP.
  - For a sub-word store, replace only the addressed lane with the low byte/half of `req_wdata`, put the result on `writeData`, then → WRITE.
- WRITE: `writeEnable` = (state==WRITE) for exactly one cycle, then → RESP.
- RESP: `resp_valid`=1 for one cycle, then → IDLE. `req_ready`=0 in every state except IDLE.
- Reset values: state IDLE, `Address`=0, `writeData`=0, `writeEnable`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `req_ready`=1.
- Requests presented while `Reset` is high are ignored.
- Reset mid-operation: the request is abandoned with no response.
  - `Reset` asserted during a READ of a sub-word store → no write occurs.
  - `Reset` asserted in the WRITE cycle does not cancel that write, because `Memory` samples on the same edge.

## Timing
Cycle 0 is the accepting edge.
- Word store: WRITE in cycle 1, `resp_valid` in cycle 2.
- Load: READ in cycles 1..L, `resp_valid` in cycle L+1.
- Sub-word store: READ in cycles 1..L, WRITE in cycle L+1, `resp_valid` in cycle L+2.
- Error: `resp_valid` in cycle 1.
- Back-to-back: earliest next acceptance is the cycle after `resp_valid`. Throughput is one request per (latency+1) cycles.
- `Address` is stable from cycle 1 until the unit returns to IDLE. `writeData` is stable during WRITE.

## Structure
- Package `mips_mem_pkg`:
  - size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`;
  - FSM state enum;
  - byte-lane width constants.
- Sub-module `mem_lane_merge` (combinational):
  - load extract/extend from (word, offset, size, signed);
  - store merge from (old word, new data, offset, size).
- FSM and registers stay in `mem_access_unit`.

## Test plan
1. **Word store.** Store word 0xF0F0F0F0 to 0x0000000C. Required: `writeEnable`=1 only in cycle 1, with `Address`=0x0C and `writeData`=0xF0F0F0F0. `resp_valid` in cycle 2 with `resp_err`=0.
2. **Byte loads.** Memory[0x0C]=0x11A23344, L=1, load byte at 0x0D. Required: signed → `resp_rdata`=0xFFFFFFA2 in cycle 2; unsigned → 0x000000A2. `writeEnable` stays 0.
3. **Byte store.** Memory[0x0C]=0x11223344, store byte 0x55 (`req_wdata`=0xFFFFFF55) to 0x0E. Required: read in cycle 1, then `writeData`=0x11225544 with `writeEnable`=1 in cycle 2, `resp_valid` in cycle 3.
4. **Misaligned.** Load half at 0x0F. Required: `resp_err`=1 with `resp_valid` in cycle 1, `resp_rdata`=0. `Address` is unchanged and `writeEnable` is never asserted.
5. **Reset mid-operation.** Assert `Reset` during READ of the test-3 store. Required: no `writeEnable`, no `resp_valid`; `req_ready`=1 on the cycle after `Reset` falls; Memory[0x0C] still 0x11223344.
6. **Back-to-back.** Hold `req_valid` high for two word loads (0x0C, then 0xFC), with L=3. Required: the second request is accepted only on the edge after the first `resp_valid`. Each `resp_valid` is 4 cycles after its acceptance.
